count_seq_monitor: RTL

// - Observer and checker for the WIDTH-bit synchronous up/down counter (ports set/count/inc -> q/cout).
// - Sees the same control inputs as the counter and predicts q and cout each cycle.
// - Compares the prediction against the counter's actual q/cout and reports mismatches and wrap events.
// - Instantiated beside the counter in benches and in self-test builds; this is the reader side of the counter interface.

---
 rtl/count_seq_monitor_pkg.sv | 16 +
 rtl/count_seq_monitor_sat_counter.sv | 40 ++++
 rtl/count_seq_monitor.sv | 117 +++++++++++
 3 files changed

// File: rtl/count_seq_monitor_pkg.sv
// cnt_mon_pkg: shared definitions for the counter sequence monitor.
//   state_t     - monitor FSM states (IDLE, TRACK, ERR), 2-bit encoding
//   DEF_WIDTH   - default counter width
//   MAXV        - all-ones value of a DEF_WIDTH counter (default load value)
package cnt_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned MAXV      = (1 << DEF_WIDTH) - 1;

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// sat_counter: W-bit event counter that stops at all-ones instead of wrapping.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   synchronous active-low reset (clears the count)
//   inc   in   count one event this cycle
//   clr   in   synchronous clear, takes priority over inc
//   cnt   out  current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: watches the control inputs of a WIDTH-bit up/down
// counter, predicts its q/cout every cycle and flags disagreements.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   set, count, inc       counter controls (load, enable, direction)
//   q, cout               counter outputs under check
//   synced                a load has been seen, prediction is meaningful
//   exp_q                 predicted counter value for this cycle
//   mismatch              pulse: last cycle's q/cout disagreed with prediction
//   err_sticky            held error flag, cleared by reset or set
//   err_count, wrap_count saturating totals of mismatches and predicted wraps
module count_seq_monitor
  import cnt_mon_pkg::*;
#(
  parameter int unsigned     WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SET_VALUE = WIDTH'(MAXV),
  parameter int unsigned     CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             count,
  input  logic             inc,
  input  logic [WIDTH-1:0] q,
  input  logic             cout,
  output logic             synced,
  output logic [WIDTH-1:0] exp_q,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic             pcout_q, pcout_d;
  logic             mismatch_q;
  logic             sticky_q, sticky_d;
  logic             cmp;

  // Prediction runs in every state; only the comparison is gated by the FSM.
  always_comb begin
    pred_d  = pred_q;
    pcout_d = 1'b0;
    if (set) begin
      pred_d = SET_VALUE;
    end else if (count) begin
      if (inc) begin
        pred_d  = pred_q + WIDTH'(1);
        pcout_d = (pred_q == {WIDTH{1'b1}});
      end else begin
        pred_d  = pred_q - WIDTH'(1);
        pcout_d = (pred_q == '0);
      end
    end
  end

  // Compare the counter's current outputs against the current prediction.
  assign cmp = (state_q != IDLE) && ((q != pred_q) || (cout != pcout_q));

  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE:    if (set) state_d = TRACK;
      TRACK:   if (set) state_d = TRACK; else if (cmp) state_d = ERR;
      ERR:     if (set) state_d = TRACK;
      default: state_d = IDLE;
    endcase
    // A simultaneous set wins over a new error for the sticky flag only;
    // the mismatch itself is still pulsed and counted.
    if (set) begin
      sticky_d = 1'b0;
    end else if (cmp) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pred_q     <= '0;
      pcout_q    <= 1'b0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pred_q     <= pred_d;
      pcout_q    <= pcout_d;
      mismatch_q <= cmp;
      sticky_q   <= sticky_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cmp),
    .clr   (1'b0),
    .cnt   (err_count)
  );

  // A wrap is counted when the predicted carry/borrow is loaded with 1.
  sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pcout_d),
    .clr   (1'b0),
    .cnt   (wrap_count)
  );

  assign synced     = (state_q != IDLE);
  assign exp_q      = pred_q;
  assign mismatch   = mismatch_q;
  assign err_sticky = sticky_q;

endmodule
